// File: rtl/ascon_round_scheduler_pkg.sv
// Shared types, sizing constants and the round-constant helper for the ASCON
// round scheduler.
package ascon_round_scheduler_pkg;

   localparam int MAX_ROUNDS = 12;
   localparam int IDX_WIDTH  = 4;
   localparam int RC_WIDTH   = 8;

   localparam logic [IDX_WIDTH-1:0] ROUNDS_MAX = IDX_WIDTH'(MAX_ROUNDS);
   localparam logic [IDX_WIDTH-1:0] LAST_IDX   = IDX_WIDTH'(MAX_ROUNDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sched_state_t;

   // ASCON constant: upper nibble is the inverted index, lower nibble the index.
   function automatic logic [RC_WIDTH-1:0] round_constant(input logic [IDX_WIDTH-1:0] idx);
      return {~idx, idx};
   endfunction

endpackage

// File: rtl/ascon_round_scheduler_if.sv
// Request handshake, datapath control and round outputs between the ASCON mode
// FSM (master) and the round scheduler (slave).
interface ascon_round_scheduler_if;
   import ascon_round_scheduler_pkg::*;

   logic                 req_valid;
   logic [IDX_WIDTH-1:0] req_rounds;
   logic                 req_ready;
   logic                 round_stall;
   logic                 abort;
   logic                 round_valid;
   logic [IDX_WIDTH-1:0] round_idx;
   logic [RC_WIDTH-1:0]  round_const;
   logic                 first_round;
   logic                 last_round;
   logic                 done;
   logic                 err;

   modport master (
      output req_valid, req_rounds, round_stall, abort,
      input  req_ready, round_valid, round_idx, round_const,
             first_round, last_round, done, err
   );

   modport slave (
      input  req_valid, req_rounds, round_stall, abort,
      output req_ready, round_valid, round_idx, round_const,
             first_round, last_round, done, err
   );

endinterface

// File: rtl/ascon_round_scheduler_round_counter.sv
// Loadable up-counter that stops at TERMINAL; load takes priority over enable.
module ascon_round_scheduler_round_counter #(
   parameter int                    DATA_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] TERMINAL   = '1
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_load_val,
   input  logic                  i_en,
   output logic [DATA_WIDTH-1:0] o_count,
   output logic                  o_terminal
);

   logic [DATA_WIDTH-1:0] r_count;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && !o_terminal) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count    = r_count;
   assign o_terminal = (r_count == TERMINAL);

endmodule

// File: rtl/ascon_round_scheduler.sv
// Steps the ASCON round index from (12 - rounds) to 11 for one p^a/p^b call
// and emits the matching round constant.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | ready for a request; illegal counts pulse err
// ST_RUN  | round_idx/round_const valid, advancing on !stall
// ST_DONE | one-cycle done pulse, then back to idle
module ascon_round_scheduler
   import ascon_round_scheduler_pkg::*;
(
   input  logic                    i_clock,
   input  logic                    i_reset_n,
   ascon_round_scheduler_if.slave  bus
);

   sched_state_t         r_state;
   logic                 r_err;
   logic [IDX_WIDTH-1:0] r_first_idx;
   logic [RC_WIDTH-1:0]  r_rc;

   logic                 w_req_legal;
   logic                 w_load;
   logic [IDX_WIDTH-1:0] w_load_val;
   logic                 w_step;
   logic [IDX_WIDTH-1:0] w_count;
   logic                 w_terminal;

   assign w_req_legal = (bus.req_rounds != '0) && (bus.req_rounds <= ROUNDS_MAX);
   assign w_load      = (r_state == ST_IDLE) && bus.req_valid && w_req_legal;
   assign w_load_val  = ROUNDS_MAX - bus.req_rounds;
   assign w_step      = (r_state == ST_RUN) && !bus.abort && !bus.round_stall && !w_terminal;

   ascon_round_scheduler_round_counter #(
      .DATA_WIDTH (IDX_WIDTH),
      .TERMINAL   (LAST_IDX)
   ) u_round_counter (
      .i_clock    (i_clock),
      .i_reset_n  (i_reset_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_en       (w_step),
      .o_count    (w_count),
      .o_terminal (w_terminal)
   );

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= ST_IDLE;
         r_err       <= 1'b0;
         r_first_idx <= '0;
         r_rc        <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  if (w_req_legal) begin
                     r_state     <= ST_RUN;
                     r_first_idx <= w_load_val;
                     r_rc        <= round_constant(w_load_val);
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               // abort outranks both stall and the final-round exit
               if (bus.abort) begin
                  r_state <= ST_IDLE;
               end else if (!bus.round_stall) begin
                  if (w_terminal) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_rc <= round_constant(w_count + 4'd1);
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = (r_state == ST_IDLE);
   assign bus.round_valid = (r_state == ST_RUN);
   assign bus.round_idx   = w_count;
   assign bus.round_const = r_rc;
   assign bus.first_round = (r_state == ST_RUN) && (w_count == r_first_idx);
   assign bus.last_round  = (r_state == ST_RUN) && w_terminal;
   assign bus.done        = (r_state == ST_DONE);
   assign bus.err         = r_err;

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Bench for ascon_round_scheduler: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a job-level model.
module tb_ascon_round_scheduler;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ascon_round_scheduler_if bus();

   ascon_round_scheduler dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Job-level model: is a job running, which round it is on, pending pulses.
   bit m_run, m_done, m_err;
   int m_idx, m_first;
   bit nd, ne;
   int rq;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_done = 0; m_err = 0; m_idx = 0; m_first = 0;
      end else begin
         nd = 0; ne = 0;
         if (m_run) begin
            if (bus.abort) m_run = 0;
            else if (!bus.round_stall) begin
               if (m_idx == 11) begin m_run = 0; nd = 1; end
               else m_idx = m_idx + 1;
            end
         end else if (!m_done && bus.req_valid) begin
            rq = int'(bus.req_rounds);
            if (rq >= 1 && rq <= 12) begin
               m_run = 1; m_idx = 12 - rq; m_first = m_idx;
            end else ne = 1;
         end
         m_done = nd;
         m_err  = ne;
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("req_ready",   32'(bus.req_ready),   32'(!m_run && !m_done));
         check("round_valid", 32'(bus.round_valid), 32'(m_run));
         check("round_idx",   32'(bus.round_idx),   32'(m_idx));
         if (m_run) check("round_const", 32'(bus.round_const), 32'((15 - m_idx) * 16 + m_idx));
         check("first_round", 32'(bus.first_round), 32'(m_run && m_idx == m_first));
         check("last_round",  32'(bus.last_round),  32'(m_run && m_idx == 11));
         check("done",        32'(bus.done),        32'(m_done));
         check("err",         32'(bus.err),         32'(m_err));
      end
   end

   task automatic request(input int r);
      bus.req_valid  = 1'b1;
      bus.req_rounds = 4'(r);
      @(negedge clk);
      bus.req_valid  = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(bus.req_ready),   32'd1);
      check({tag, "_valid"}, 32'(bus.round_valid), 32'd0);
      check({tag, "_idx"},   32'(bus.round_idx),   32'd0);
      check({tag, "_rc"},    32'(bus.round_const), 32'd0);
      check({tag, "_first"}, 32'(bus.first_round), 32'd0);
      check({tag, "_last"},  32'(bus.last_round),  32'd0);
      check({tag, "_done"},  32'(bus.done),        32'd0);
      check({tag, "_err"},   32'(bus.err),         32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_rounds = '0; bus.round_stall = 1'b0; bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      rst_n = 1'b1;
      chk_on = 1'b1;
      @(negedge clk);

      // p12: idx 0..11, rc 0xF0..0x4B, done at T+13
      request(12);
      check("p12_first_idx", 32'(bus.round_idx),   32'd0);
      check("p12_first_rc",  32'(bus.round_const), 32'hF0);
      check("p12_first_flag",32'(bus.first_round), 32'd1);
      repeat (11) @(negedge clk);
      check("p12_last_idx",  32'(bus.round_idx),   32'd11);
      check("p12_last_rc",   32'(bus.round_const), 32'h4B);
      check("p12_last_flag", 32'(bus.last_round),  32'd1);
      @(negedge clk);
      check("p12_done",      32'(bus.done),        32'd1);
      @(negedge clk);
      check("p12_ready",     32'(bus.req_ready),   32'd1);

      // p6 with two stall cycles at idx 8
      request(6);
      check("p6_first_idx",  32'(bus.round_idx), 32'd6);
      @(negedge clk);
      @(negedge clk);
      check("p6_idx8_a",     32'(bus.round_idx), 32'd8);
      bus.round_stall = 1'b1;
      @(negedge clk);
      check("p6_idx8_b",     32'(bus.round_idx), 32'd8);
      @(negedge clk);
      check("p6_idx8_c",     32'(bus.round_idx), 32'd8);
      check("p6_rc8",        32'(bus.round_const), 32'h78);
      bus.round_stall = 1'b0;
      repeat (4) @(negedge clk);
      check("p6_done",       32'(bus.done), 32'd1);
      @(negedge clk);

      // illegal counts 0 and 13
      request(0);
      check("ill0_err",   32'(bus.err),         32'd1);
      check("ill0_valid", 32'(bus.round_valid), 32'd0);
      check("ill0_ready", 32'(bus.req_ready),   32'd1);
      @(negedge clk);
      request(13);
      check("ill13_err",   32'(bus.err),         32'd1);
      check("ill13_valid", 32'(bus.round_valid), 32'd0);
      @(negedge clk);

      // abort at idx 7 of p8, then a fresh p12 runs to completion
      request(8);
      repeat (3) @(negedge clk);
      check("ab_idx7", 32'(bus.round_idx), 32'd7);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("ab_valid", 32'(bus.round_valid), 32'd0);
      check("ab_done",  32'(bus.done),        32'd0);
      check("ab_ready", 32'(bus.req_ready),   32'd1);
      request(12);
      check("ab_new_idx", 32'(bus.round_idx), 32'd0);
      repeat (13) @(negedge clk);

      // abort coincident with the last round
      request(2);
      @(negedge clk);
      check("ab11_last", 32'(bus.last_round), 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("ab11_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      check("ab11_done2", 32'(bus.done), 32'd0);

      // single-round request
      request(1);
      check("p1_idx",   32'(bus.round_idx),   32'd11);
      check("p1_first", 32'(bus.first_round), 32'd1);
      check("p1_last",  32'(bus.last_round),  32'd1);
      @(negedge clk);
      check("p1_done",  32'(bus.done), 32'd1);
      @(negedge clk);

      // reset asserted mid-run at idx 5
      request(12);
      repeat (5) @(negedge clk);
      check("mr_idx5", 32'(bus.round_idx), 32'd5);
      rst_n = 1'b0;
      #1;
      check_reset_values("mr");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_ready", 32'(bus.req_ready), 32'd1);

      // randomized traffic, checked by the per-cycle compare
      repeat (400) begin
         bus.req_valid   = ($urandom_range(0, 2) == 0);
         bus.req_rounds  = 4'($urandom_range(0, 15));
         bus.round_stall = ($urandom_range(0, 3) == 0);
         bus.abort       = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      bus.req_valid = 1'b0; bus.round_stall = 1'b0; bus.abort = 1'b0;
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
